// File: rtl/chacha_pkg.sv
// Shared ChaCha constants and serializer state encoding, used by block core and serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chacha_pkg;

    localparam int CHACHA_WORDS    = 16;
    localparam int BLOCK_BITS      = 512;
    localparam int BYTES_PER_BLOCK = 64;

    typedef enum logic {
        SER_IDLE   = 1'b0,
        SER_STREAM = 1'b1
    } ser_state_t;

endpackage

// File: rtl/chacha_keystream_serializer.sv
// Streams one captured 512-bit ChaCha block as 64 bytes (optionally XORed with byte_in).
// Latency: byte 0 valid the cycle after block capture; one byte per cycle; ctr_inc the cycle after byte 63.
// Backpressure: byte_ready=0 holds idx/byte_out; blk_ready only in IDLE (registered, no comb path from inputs).
//
// Ports:
//   clk, rst_n                - clock, async active-low reset
//   blk_data/blk_valid/blk_ready - block capture handshake (little-endian: byte k = bits [8k+7:8k])
//   flush                     - synchronous abort, overrides both handshakes
//   xor_en, byte_in           - optional XOR of keystream with the paired data byte
//   byte_out/byte_valid/byte_ready/byte_last - byte stream toward the pin mux
//   ctr_inc                   - one-cycle pulse asking the core to advance its block counter
module chacha_keystream_serializer #(
    parameter int BYTES_PER_BLOCK = chacha_pkg::BYTES_PER_BLOCK,
    parameter int BLOCK_BITS      = chacha_pkg::BLOCK_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BLOCK_BITS-1:0] blk_data,
    input  logic                  blk_valid,
    output logic                  blk_ready,
    input  logic                  flush,
    input  logic                  xor_en,
    input  logic [7:0]            byte_in,
    output logic [7:0]            byte_out,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic                  byte_last,
    output logic                  ctr_inc
);

    import chacha_pkg::*;

    localparam int               IDX_W    = $clog2(BYTES_PER_BLOCK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_BLOCK - 1);

    ser_state_t              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BLOCK_BITS-1:0]   buf_q, buf_d;
    logic                    ctr_inc_q, ctr_inc_d;

    logic [7:0]              blk_bytes [BYTES_PER_BLOCK];
    logic [7:0]              ks_byte;

    // Outputs depend only on registered state, so downstream ready/valid
    // never loops combinationally back into our own ready/valid.
    assign blk_ready  = (state_q == SER_IDLE);
    assign byte_valid = (state_q == SER_STREAM);
    assign byte_last  = (state_q == SER_STREAM) && (idx_q == LAST_IDX);
    assign ctr_inc    = ctr_inc_q;

    // 64:1 byte select from the registered block.
    always_comb begin
        for (int k = 0; k < BYTES_PER_BLOCK; k++) begin
            blk_bytes[k] = buf_q[8*k +: 8];
        end
    end

    assign ks_byte  = blk_bytes[idx_q];
    assign byte_out = ks_byte ^ (byte_in & {8{xor_en}});

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        ctr_inc_d = 1'b0;

        case (state_q)
            SER_IDLE: begin
                if (blk_valid) begin
                    buf_d   = blk_data;
                    idx_d   = '0;
                    state_d = SER_STREAM;
                end
            end
            SER_STREAM: begin
                if (byte_ready) begin
                    if (idx_q == LAST_IDX) begin
                        // Block done: never wrap into a second pass of the same block.
                        idx_d     = '0;
                        state_d   = SER_IDLE;
                        ctr_inc_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = SER_IDLE;
                idx_d   = '0;
            end
        endcase

        // Flush discards everything decided above; the buffer is left as-is
        // since it is unreachable until the next capture overwrites it.
        if (flush) begin
            state_d   = SER_IDLE;
            idx_d     = '0;
            buf_d     = buf_q;
            ctr_inc_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SER_IDLE;
            idx_q     <= '0;
            buf_q     <= '0;
            ctr_inc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            ctr_inc_q <= ctr_inc_d;
        end
    end

endmodule

// File: tb/tb_chacha_keystream_serializer.sv
// Scoreboard bench for chacha_keystream_serializer: expected bytes are queued at block
// submission and popped as the DUT hands bytes over.
module tb_chacha_keystream_serializer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         flush;
    logic         xor_en;
    logic [7:0]   byte_in;
    logic [7:0]   byte_out;
    logic         byte_valid;
    logic         byte_ready;
    logic         byte_last;
    logic         ctr_inc;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sb[$];
    logic [7:0] obs_q[$];
    bit         last_q[$];
    int  valid_cycles, unstable, ctr_pulses, ctr_cyc, hs_last_cyc;
    bit  rdy_at_ctr, timed_out;

    logic [31:0] rfc_w [16] = '{
        32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
        32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
        32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
        32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};
    logic [511:0] rfc_blk;
    logic [511:0] rnd_blk;

    chacha_keystream_serializer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .blk_data   (blk_data),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .flush      (flush),
        .xor_en     (xor_en),
        .byte_in    (byte_in),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_last  (byte_last),
        .ctr_inc    (ctr_inc)
    );

    always #5 clk = ~clk;

    // Expected keystream byte k taken from word k/4, little-endian within the word.
    function automatic logic [7:0] word_byte(input logic [511:0] b, input int k);
        logic [31:0] w;
        w = b[32*(k/4) +: 32];
        return 8'(w >> (8*(k%4)));
    endfunction

    // Presents a block, queues its 64 expected bytes, returns just after the capture edge.
    task automatic send_block(input logic [511:0] d, input logic xen, input logic [7:0] bi);
        @(negedge clk);
        blk_data  = d;
        blk_valid = 1'b1;
        for (int k = 0; k < 64; k++) sb.push_back(word_byte(d, k) ^ (xen ? bi : 8'h00));
        for (int i = 0; i < 10; i++) begin
            if (blk_ready) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1 blk_valid = 1'b0;
    endtask

    // Drives byte_ready/xor/byte_in and records what the DUT emits until two cycles after ctr_inc.
    task automatic collect(input int max_cyc, input int rdy_pct, input logic xen, input logic [7:0] bi);
        bit         pv, pr;
        logic [7:0] po;
        obs_q.delete(); last_q.delete();
        valid_cycles = 0; unstable = 0; ctr_pulses = 0; ctr_cyc = -1; hs_last_cyc = -1;
        rdy_at_ctr = 1'b0; timed_out = 1'b1; pv = 1'b0; pr = 1'b0; po = 8'h00;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            byte_ready = ($urandom_range(99) < rdy_pct);
            xor_en     = xen;
            byte_in    = bi;
            #1;
            if (ctr_inc) begin
                ctr_pulses++;
                if (ctr_cyc < 0) begin
                    ctr_cyc    = cyc;
                    rdy_at_ctr = blk_ready;
                end
            end
            if (byte_valid) begin
                valid_cycles++;
                if (pv && !pr && byte_out !== po) unstable++;
                if (byte_ready) begin
                    obs_q.push_back(byte_out);
                    last_q.push_back(byte_last);
                    if (byte_last) hs_last_cyc = cyc;
                end
            end
            pv = byte_valid; pr = byte_ready; po = byte_out;
            if (ctr_cyc >= 0 && cyc == ctr_cyc + 2) begin
                timed_out = 1'b0;
                break;
            end
        end
        byte_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; blk_valid = 1'b0; blk_data = '0; flush = 1'b0;
        xor_en = 1'b1; byte_in = 8'h5a; byte_ready = 1'b0;
        #12;
        n_cmp++; if (blk_ready !== 1'b1)  begin n_err++; $display("FAIL reset_blk_ready got %b want 1", blk_ready); end
        n_cmp++; if (byte_valid !== 1'b0) begin n_err++; $display("FAIL reset_byte_valid got %b want 0", byte_valid); end
        n_cmp++; if (byte_last !== 1'b0)  begin n_err++; $display("FAIL reset_byte_last got %b want 0", byte_last); end
        n_cmp++; if (ctr_inc !== 1'b0)    begin n_err++; $display("FAIL reset_ctr_inc got %b want 0", ctr_inc); end
        n_cmp++; if (byte_out !== 8'h5a)  begin n_err++; $display("FAIL reset_byte_out got %h want 5a", byte_out); end
        @(negedge clk);
        rst_n = 1'b1; xor_en = 1'b0; byte_in = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_rfc_block();
        logic [7:0] exp;
        int last_cnt;
        send_block(rfc_blk, 1'b0, 8'h00);
        collect(300, 100, 1'b0, 8'h00);
        n_cmp++; if (timed_out)          begin n_err++; $display("FAIL rfc_timeout got no ctr_inc want pulse"); end
        n_cmp++; if (obs_q.size() != 64) begin n_err++; $display("FAIL rfc_count got %0d want 64", obs_q.size()); end
        if (obs_q.size() >= 4) begin
            n_cmp++;
            if ({obs_q[3], obs_q[2], obs_q[1], obs_q[0]} !== 32'he4e7f110) begin
                n_err++;
                $display("FAIL rfc_first4 got %h %h %h %h want 10 f1 e7 e4", obs_q[0], obs_q[1], obs_q[2], obs_q[3]);
            end
        end
        foreach (obs_q[i]) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            n_cmp++; if (obs_q[i] !== exp) begin n_err++; $display("FAIL rfc_byte%0d got %h want %h", i, obs_q[i], exp); end
        end
        sb.delete();
        n_cmp++; if (valid_cycles != 64) begin n_err++; $display("FAIL rfc_valid_cycles got %0d want 64", valid_cycles); end
        last_cnt = 0;
        foreach (last_q[i]) if (last_q[i]) last_cnt++;
        n_cmp++; if (last_cnt != 1 || last_q.size() != 64 || !last_q[63]) begin
            n_err++; $display("FAIL rfc_byte_last got %0d flags want 1 on byte 63", last_cnt);
        end
        n_cmp++; if (ctr_pulses != 1) begin n_err++; $display("FAIL rfc_ctr_pulses got %0d want 1", ctr_pulses); end
        n_cmp++; if (ctr_cyc != hs_last_cyc + 1) begin
            n_err++; $display("FAIL rfc_ctr_timing got cycle %0d want %0d", ctr_cyc, hs_last_cyc + 1);
        end
        n_cmp++; if (rdy_at_ctr !== 1'b1) begin n_err++; $display("FAIL rfc_ready_at_ctr got %b want 1", rdy_at_ctr); end
    endtask

    task automatic test_stall();
        logic [7:0] exp;
        send_block(rfc_blk, 1'b0, 8'h00);
        collect(2000, 50, 1'b0, 8'h00);
        n_cmp++; if (timed_out || obs_q.size() != 64) begin
            n_err++; $display("FAIL stall_count got %0d want 64", obs_q.size());
        end
        foreach (obs_q[i]) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            n_cmp++; if (obs_q[i] !== exp) begin n_err++; $display("FAIL stall_byte%0d got %h want %h", i, obs_q[i], exp); end
        end
        sb.delete();
        n_cmp++; if (unstable != 0) begin n_err++; $display("FAIL stall_stable got %0d changes want 0", unstable); end
        n_cmp++; if (valid_cycles <= 64) begin n_err++; $display("FAIL stall_exercised got %0d valid cycles want >64", valid_cycles); end
    endtask

    task automatic test_xor();
        logic [7:0] exp;
        send_block(rfc_blk, 1'b1, 8'hff);
        collect(300, 100, 1'b1, 8'hff);
        n_cmp++; if (obs_q.size() != 64) begin n_err++; $display("FAIL xor_count got %0d want 64", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            n_cmp++; if (obs_q[0] !== 8'hef) begin n_err++; $display("FAIL xor_byte0 got %h want ef", obs_q[0]); end
        end
        foreach (obs_q[i]) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            n_cmp++; if (obs_q[i] !== exp) begin n_err++; $display("FAIL xor_byte%0d got %h want %h", i, obs_q[i], exp); end
        end
        sb.delete();
        xor_en = 1'b0; byte_in = 8'h00;
    endtask

    task automatic test_back_to_back();
        int         caps[$];
        int         ctrs[$];
        int         bad_rdy;
        logic [7:0] exp;
        sb.delete();
        bad_rdy = 0;
        for (int cyc = 0; cyc < 140; cyc++) begin
            @(negedge clk);
            blk_data = rnd_blk; blk_valid = 1'b1; byte_ready = 1'b1;
            #1;
            if (blk_ready && blk_valid) begin
                caps.push_back(cyc);
                for (int k = 0; k < 64; k++) sb.push_back(word_byte(rnd_blk, k));
            end
            if (byte_valid) begin
                if (blk_ready) bad_rdy++;
                exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                n_cmp++; if (byte_out !== exp) begin n_err++; $display("FAIL b2b_byte cyc%0d got %h want %h", cyc, byte_out, exp); end
            end
            if (ctr_inc) ctrs.push_back(cyc);
        end
        @(negedge clk);
        blk_valid = 1'b0; byte_ready = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        sb.delete();
        n_cmp++; if (caps.size() != 3) begin n_err++; $display("FAIL b2b_captures got %0d want 3", caps.size()); end
        n_cmp++; if (caps.size() < 2 || caps[1] - caps[0] != 65) begin
            n_err++; $display("FAIL b2b_period got %0d want 65", (caps.size() < 2) ? -1 : caps[1] - caps[0]);
        end
        n_cmp++; if (ctrs.size() < 1 || caps.size() < 2 || ctrs[0] != caps[1]) begin
            n_err++; $display("FAIL b2b_capture_at_ctr got ctr %0d want capture cycle", (ctrs.size() < 1) ? -1 : ctrs[0]);
        end
        n_cmp++; if (bad_rdy != 0) begin n_err++; $display("FAIL b2b_ready_in_stream got %0d want 0", bad_rdy); end
    endtask

    task automatic test_flush();
        logic [7:0] exp;
        int         ctr_seen;
        send_block(rnd_blk, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            byte_ready = 1'b1;
            #1;
            exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            n_cmp++; if (byte_valid !== 1'b1 || byte_out !== exp) begin
                n_err++; $display("FAIL flush_pre_byte%0d got %h/%b want %h/1", i, byte_out, byte_valid, exp);
            end
        end
        @(negedge clk);
        flush = 1'b1; byte_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; byte_ready = 1'b0;
        #1;
        n_cmp++; if (byte_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", byte_valid); end
        n_cmp++; if (blk_ready !== 1'b1)  begin n_err++; $display("FAIL flush_blk_ready got %b want 1", blk_ready); end
        ctr_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (ctr_inc) ctr_seen++;
            @(negedge clk);
            #1;
        end
        n_cmp++; if (ctr_seen != 0) begin n_err++; $display("FAIL flush_ctr_inc got %0d pulses want 0", ctr_seen); end
        sb.delete();
        send_block(rnd_blk, 1'b0, 8'h00);
        collect(300, 100, 1'b0, 8'h00);
        n_cmp++; if (obs_q.size() != 64) begin n_err++; $display("FAIL flush_restart_count got %0d want 64", obs_q.size()); end
        foreach (obs_q[i]) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            n_cmp++; if (obs_q[i] !== exp) begin n_err++; $display("FAIL flush_restart_byte%0d got %h want %h", i, obs_q[i], exp); end
        end
        sb.delete();
    endtask

    task automatic test_async_reset();
        logic [7:0] exp;
        send_block(rnd_blk, 1'b0, 8'h00);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            byte_ready = 1'b1;
            #1;
            exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            n_cmp++; if (byte_out !== exp) begin n_err++; $display("FAIL arst_pre_byte%0d got %h want %h", i, byte_out, exp); end
        end
        @(negedge clk);
        byte_ready = 1'b0;
        #2;
        rst_n = 1'b0; xor_en = 1'b1; byte_in = 8'h3c;
        #1;
        n_cmp++; if (blk_ready !== 1'b1)  begin n_err++; $display("FAIL arst_blk_ready got %b want 1", blk_ready); end
        n_cmp++; if (byte_valid !== 1'b0) begin n_err++; $display("FAIL arst_byte_valid got %b want 0", byte_valid); end
        n_cmp++; if (byte_last !== 1'b0)  begin n_err++; $display("FAIL arst_byte_last got %b want 0", byte_last); end
        n_cmp++; if (ctr_inc !== 1'b0)    begin n_err++; $display("FAIL arst_ctr_inc got %b want 0", ctr_inc); end
        n_cmp++; if (byte_out !== 8'h3c)  begin n_err++; $display("FAIL arst_byte_out got %h want 3c", byte_out); end
        @(negedge clk);
        rst_n = 1'b1; xor_en = 1'b0; byte_in = 8'h00;
        sb.delete();
        send_block(rfc_blk, 1'b0, 8'h00);
        collect(300, 100, 1'b0, 8'h00);
        n_cmp++; if (obs_q.size() != 64) begin n_err++; $display("FAIL arst_restart_count got %0d want 64", obs_q.size()); end
        foreach (obs_q[i]) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            n_cmp++; if (obs_q[i] !== exp) begin n_err++; $display("FAIL arst_restart_byte%0d got %h want %h", i, obs_q[i], exp); end
        end
        sb.delete();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            rfc_blk[32*i +: 32] = rfc_w[i];
            rnd_blk[32*i +: 32] = $urandom;
        end
        test_reset();
        test_rfc_block();
        test_stall();
        test_xor();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
